// File: rtl/booth_divider_if.sv
// Request/result bundle for booth_divider.
// BOOTH_DIVIDER_UNSIGNED_EN adds the is_signed request bit.
interface booth_divider_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
`ifdef BOOTH_DIVIDER_UNSIGNED_EN
    logic                   is_signed;
`endif
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   ovf;
    logic                   dbz;

`ifdef BOOTH_DIVIDER_UNSIGNED_EN
    modport master (output start, dividend, divisor, is_signed,
                    input  busy, done, quotient, remainder, ovf, dbz);
    modport slave  (input  start, dividend, divisor, is_signed,
                    output busy, done, quotient, remainder, ovf, dbz);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, ovf, dbz);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, ovf, dbz);
`endif
endinterface

// File: rtl/booth_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Non-restoring iteration on magnitudes, one quotient bit per clock,
// fixed latency, saturating quotient with ovf/dbz flags.
// Optional macro BOOTH_DIVIDER_UNSIGNED_EN adds a per-request is_signed bit.
module booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_divider_if.slave  bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    // Largest magnitude allowed for a negative quotient; one less for positive.
    localparam logic [DW-1:0] NEG_LIM = {{(DW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DW-1:0] POS_LIM = NEG_LIM - DW'(1);

    typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

    state_t             state_reg;
    logic [DW-1:0]      dvd_reg;
    logic [WIDTH-1:0]   dvs_reg;
    logic               qsign_reg;
    logic               rsign_reg;
    logic               dz_reg;
    logic [WIDTH-1:0]   dmag_reg;
    logic [WIDTH:0]     rem_reg;     // signed partial remainder
    logic [DW-1:0]      quo_reg;     // dividend bits shift out, quotient bits shift in
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               ovf_reg;
    logic               dbz_reg;
    logic               op_signed;

`ifdef BOOTH_DIVIDER_UNSIGNED_EN
    logic               sgn_reg;
    assign op_signed = sgn_reg;
`else
    assign op_signed = 1'b1;
`endif

    logic [WIDTH:0]     dext;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH:0]     rem_fix;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo_lo;
    logic               quo_ovf;
    logic [WIDTH-1:0]   sat_pos;
    logic [WIDTH-1:0]   sat_neg;
    logic [WIDTH-1:0]   q_final;
    logic [WIDTH-1:0]   r_final;
    logic               ovf_final;
    logic               dbz_final;

    // Datapath: one non-restoring step plus the final sign/saturation stage.
    always_comb begin
        dext      = {1'b0, dmag_reg};
        rem_shift = {rem_reg[WIDTH-1:0], quo_reg[DW-1]};
        rem_next  = rem_reg[WIDTH] ? rem_shift + dext : rem_shift - dext;
        rem_fix   = rem_reg[WIDTH] ? rem_reg + dext : rem_reg;
        rem_mag   = rem_fix[WIDTH-1:0];
        quo_lo    = quo_reg[WIDTH-1:0];
        if (op_signed) begin
            quo_ovf = qsign_reg ? (quo_reg > NEG_LIM) : (quo_reg > POS_LIM);
            sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
            sat_neg = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            quo_ovf = |quo_reg[DW-1:WIDTH];
            sat_pos = '1;
            sat_neg = '1;
        end
        q_final   = qsign_reg ? -quo_lo : quo_lo;
        r_final   = rsign_reg ? -rem_mag : rem_mag;
        ovf_final = 1'b0;
        dbz_final = 1'b0;
        if (dz_reg) begin
            // Divide by zero saturates toward the dividend's sign.
            q_final   = rsign_reg ? sat_neg : sat_pos;
            r_final   = '0;
            dbz_final = 1'b1;
        end else if (quo_ovf) begin
            q_final   = qsign_reg ? sat_neg : sat_pos;
            r_final   = '0;
            ovf_final = 1'b1;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            qsign_reg     <= 1'b0;
            rsign_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            dmag_reg      <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            ovf_reg       <= 1'b0;
            dbz_reg       <= 1'b0;
`ifdef BOOTH_DIVIDER_UNSIGNED_EN
            sgn_reg       <= 1'b1;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    state_reg <= IDLE;
                    if (bus.start) begin
                        dvd_reg   <= bus.dividend;
                        dvs_reg   <= bus.divisor;
`ifdef BOOTH_DIVIDER_UNSIGNED_EN
                        sgn_reg   <= bus.is_signed;
`endif
                        busy_reg  <= 1'b1;
                        state_reg <= PREP;
                    end
                end
                PREP: begin
                    quo_reg   <= (op_signed && dvd_reg[DW-1]) ? -dvd_reg : dvd_reg;
                    dmag_reg  <= (op_signed && dvs_reg[WIDTH-1]) ? -dvs_reg : dvs_reg;
                    qsign_reg <= op_signed && (dvd_reg[DW-1] ^ dvs_reg[WIDTH-1]);
                    rsign_reg <= op_signed && dvd_reg[DW-1];
                    dz_reg    <= (dvs_reg == '0);
                    rem_reg   <= '0;
                    cnt_reg   <= CW'(DW - 1);
                    state_reg <= DIV;
                end
                DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[DW-2:0], ~rem_next[WIDTH]};
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    quotient_reg  <= q_final;
                    remainder_reg <= r_final;
                    ovf_reg       <= ovf_final;
                    dbz_reg       <= dbz_final;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                    state_reg     <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.dbz       = dbz_reg;
endmodule
